// File: rtl/ethercat_pkg.sv
// ethercat_pkg
//   Shared definitions for the EtherCAT receive path: parser FSM state
//   encoding, frame layout constants and datagram command codes (the command
//   codes are shared with ethercat_fmmu).
package ethercat_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_PRE  = 4'd1,
    ST_MAC  = 4'd2,
    ST_ETYP = 4'd3,
    ST_ECAT = 4'd4,
    ST_DGH  = 4'd5,
    ST_DGD  = 4'd6,
    ST_WKC  = 4'd7,
    ST_DROP = 4'd8,
    ST_DONE = 4'd9
  } state_t;

  localparam logic [15:0] ETHERTYPE_ECAT = 16'h88A4;
  localparam logic [3:0]  PREAMBLE_NIB   = 4'h5;
  localparam logic [3:0]  SFD_NIB        = 4'hD;

  localparam logic [10:0] MAC_BYTES      = 11'd12;
  localparam logic [10:0] ETYP_BYTES     = 11'd2;
  localparam logic [10:0] ECAT_HDR_BYTES = 11'd2;
  localparam logic [10:0] DGH_BYTES      = 11'd10;
  localparam logic [10:0] WKC_BYTES      = 11'd2;

  localparam logic [7:0] CMD_NOP  = 8'h00;
  localparam logic [7:0] CMD_APRD = 8'h01;
  localparam logic [7:0] CMD_APWR = 8'h02;
  localparam logic [7:0] CMD_APRW = 8'h03;
  localparam logic [7:0] CMD_FPRD = 8'h04;
  localparam logic [7:0] CMD_FPWR = 8'h05;
  localparam logic [7:0] CMD_FPRW = 8'h06;
  localparam logic [7:0] CMD_BRD  = 8'h07;
  localparam logic [7:0] CMD_BWR  = 8'h08;
  localparam logic [7:0] CMD_BRW  = 8'h09;
  localparam logic [7:0] CMD_LRD  = 8'h0A;
  localparam logic [7:0] CMD_LWR  = 8'h0B;
  localparam logic [7:0] CMD_LRW  = 8'h0C;

  // Index of the last byte of an n-byte field, as seen by the byte counter.
  function automatic logic [10:0] last_idx(input logic [10:0] n);
    return n - 11'd1;
  endfunction

endpackage

// File: rtl/ethercat_nibble_assembler.sv
// ethercat_nibble_assembler
//   Pairs MII nibbles (low nibble first) into bytes.
// Ports
//   rxc        in   MII receive clock
//   RSTN       in   asynchronous active-low reset
//   rx_dv      in   MII receive data valid
//   rx_data    in   MII nibble
//   clear      in   hold nibble phase at 0 (parser not inside a byte stream)
//   byte_data  out  {current nibble, stored low nibble}; valid with byte_stb
//   byte_stb   out  high in the cycle the high nibble is on rx_data
//   phase      out  1 = low nibble stored, waiting for the high nibble
module ethercat_nibble_assembler (
  input  logic       rxc,
  input  logic       RSTN,
  input  logic       rx_dv,
  input  logic [3:0] rx_data,
  input  logic       clear,
  output logic [7:0] byte_data,
  output logic       byte_stb,
  output logic       phase
);

  logic [3:0] nib_lo;

  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN) begin
      phase  <= 1'b0;
      nib_lo <= 4'h0;
    end else if (clear) begin
      phase  <= 1'b0;
    end else if (rx_dv) begin
      if (!phase) nib_lo <= rx_data;
      phase <= ~phase;
    end
  end

  // The byte is presented combinationally so the parser registers it on the
  // same edge that samples the high nibble.
  assign byte_stb  = rx_dv & phase & ~clear;
  assign byte_data = {rx_data, nib_lo};

endmodule

// File: rtl/ethercat_datagram_parser.sv
// ethercat_datagram_parser
//   MII receive front end: strips preamble/SFD, MAC addresses and EtherType,
//   skips the EtherCAT frame header, decodes datagram headers and streams
//   datagram payload bytes.
// Parameters
//   ETHERTYPE   accepted EtherType, any other value drops the frame
//   MAX_DGRAMS  datagrams allowed per frame (only with DGRAM_CHAIN_EN)
// Build option
//   DGRAM_CHAIN_EN  follow the M (more) flag through chained datagrams;
//                   when undefined only the first datagram is parsed.
// Ports
//   rxc, RSTN            clock, asynchronous active-low reset
//   rx_dv, rx_data       MII receive interface
//   sub_command/address/len, subdv   decoded header, subdv 1-cycle strobe
//   dg_data, dg_data_vld payload byte stream
//   dg_end               strobe after the working counter of a datagram
//   frame_err            strobe on truncation/alignment/overflow error
//
// state | meaning
// IDLE  | waiting for rx_dv with a preamble nibble
// PRE   | preamble nibbles, waiting for the SFD high nibble
// MAC   | skipping destination + source MAC
// ETYP  | EtherType, big-endian
// ECAT  | skipping the 2-byte EtherCAT frame header
// DGH   | 10-byte datagram header
// DGD   | datagram payload
// WKC   | skipping the 2-byte working counter
// DROP  | ignoring the rest of the frame
// DONE  | parsing finished, waiting for rx_dv to fall
module ethercat_datagram_parser
  import ethercat_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE = ETHERTYPE_ECAT
`ifdef DGRAM_CHAIN_EN
  , parameter int unsigned MAX_DGRAMS = 8
`endif
) (
  input  logic        rxc,
  input  logic        RSTN,
  input  logic        rx_dv,
  input  logic [3:0]  rx_data,
  output logic [7:0]  sub_command,
  output logic [31:0] sub_address,
  output logic [15:0] sub_len,
  output logic        subdv,
  output logic [7:0]  dg_data,
  output logic        dg_data_vld,
  output logic        dg_end,
  output logic        frame_err
);

  state_t      state, state_nxt;
  logic [7:0]  byte_data;
  logic        byte_stb;
  logic        phase;
  logic        asm_clear;
  logic [10:0] byte_cnt;
  logic [10:0] dg_len;
  logic [7:0]  etyp_hi;
  logic [7:0]  cmd_sh;
  logic [31:0] addr_sh;
  logic        subdv_d, dgv_d, dg_end_d, err_d;

`ifdef DGRAM_CHAIN_EN
  logic       m_flag;
  logic [7:0] dg_cnt;
`endif

  // Outside a byte-aligned region the nibble phase is meaningless.
  assign asm_clear = (state == ST_IDLE) || (state == ST_PRE) || (state == ST_DROP);

  ethercat_nibble_assembler u_nib (
    .rxc       (rxc),
    .RSTN      (RSTN),
    .rx_dv     (rx_dv),
    .rx_data   (rx_data),
    .clear     (asm_clear),
    .byte_data (byte_data),
    .byte_stb  (byte_stb),
    .phase     (phase)
  );

  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    subdv_d   = 1'b0;
    dgv_d     = 1'b0;
    dg_end_d  = 1'b0;
    err_d     = 1'b0;
    if (!rx_dv) begin
      // End of frame: clean only where nothing is left half-parsed.
      if (state != ST_IDLE) state_nxt = ST_IDLE;
      err_d = !((state == ST_IDLE) || (state == ST_DROP) || (state == ST_DONE)) || phase;
    end else begin
      case (state)
        ST_IDLE: begin
          // A frame that does not open with preamble is ignored to its end.
          if (rx_data == PREAMBLE_NIB) state_nxt = ST_PRE;
          else                         state_nxt = ST_DROP;
        end
        ST_PRE: begin
          if (rx_data == SFD_NIB)           state_nxt = ST_MAC;
          else if (rx_data != PREAMBLE_NIB) state_nxt = ST_DROP;
        end
        ST_MAC: begin
          if (byte_stb && byte_cnt == last_idx(MAC_BYTES)) state_nxt = ST_ETYP;
        end
        ST_ETYP: begin
          if (byte_stb && byte_cnt == last_idx(ETYP_BYTES)) begin
            if ({etyp_hi, byte_data} == ETHERTYPE) state_nxt = ST_ECAT;
            else                                   state_nxt = ST_DROP;
          end
        end
        ST_ECAT: begin
          if (byte_stb && byte_cnt == last_idx(ECAT_HDR_BYTES)) state_nxt = ST_DGH;
        end
        ST_DGH: begin
          if (byte_stb && byte_cnt == last_idx(DGH_BYTES)) begin
            subdv_d = 1'b1;
            if (dg_len == 11'd0) state_nxt = ST_WKC;
            else                 state_nxt = ST_DGD;
          end
        end
        ST_DGD: begin
          if (byte_stb) begin
            dgv_d = 1'b1;
            if (byte_cnt == last_idx(dg_len)) state_nxt = ST_WKC;
          end
        end
        ST_WKC: begin
          if (byte_stb && byte_cnt == last_idx(WKC_BYTES)) begin
            dg_end_d = 1'b1;
`ifdef DGRAM_CHAIN_EN
            if (!m_flag) begin
              state_nxt = ST_DONE;
            end else if (32'(dg_cnt) + 32'd1 < MAX_DGRAMS) begin
              state_nxt = ST_DGH;
            end else begin
              err_d     = 1'b1;
              state_nxt = ST_DROP;
            end
`else
            state_nxt = ST_DONE;
`endif
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Byte counter restarts on every state entry.
  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN)                   byte_cnt <= 11'd0;
    else if (state_nxt != state) byte_cnt <= 11'd0;
    else if (byte_stb)           byte_cnt <= byte_cnt + 11'd1;
  end

  // Header fields are collected in shadow registers and only published on
  // the tenth byte, so a truncated header never disturbs sub_*.
  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN) begin
      etyp_hi <= 8'h00;
      cmd_sh  <= 8'h00;
      addr_sh <= 32'h0;
      dg_len  <= 11'd0;
    end else if (byte_stb) begin
      if (state == ST_ETYP && byte_cnt == 11'd0) etyp_hi <= byte_data;
      if (state == ST_DGH) begin
        case (byte_cnt)
          11'd0:   cmd_sh         <= byte_data;
          11'd2:   addr_sh[7:0]   <= byte_data;
          11'd3:   addr_sh[15:8]  <= byte_data;
          11'd4:   addr_sh[23:16] <= byte_data;
          11'd5:   addr_sh[31:24] <= byte_data;
          11'd6:   dg_len[7:0]    <= byte_data;
          11'd7:   dg_len[10:8]   <= byte_data[2:0];
          default: ;
        endcase
      end
    end
  end

`ifdef DGRAM_CHAIN_EN
  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN) begin
      m_flag <= 1'b0;
      dg_cnt <= 8'd0;
    end else begin
      if (state == ST_IDLE) dg_cnt <= 8'd0;
      else if (dg_end_d)    dg_cnt <= dg_cnt + 8'd1;
      if (state == ST_DGH && byte_stb && byte_cnt == 11'd7) m_flag <= byte_data[7];
    end
  end
`endif

  always_ff @(posedge rxc or negedge RSTN) begin
    if (!RSTN) begin
      sub_command <= 8'h00;
      sub_address <= 32'h0;
      sub_len     <= 16'h0;
      subdv       <= 1'b0;
      dg_data     <= 8'h00;
      dg_data_vld <= 1'b0;
      dg_end      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      subdv       <= subdv_d;
      dg_data_vld <= dgv_d;
      dg_end      <= dg_end_d;
      frame_err   <= err_d;
      if (dgv_d) dg_data <= byte_data;
      if (subdv_d) begin
        sub_command <= cmd_sh;
        sub_address <= addr_sh;
        sub_len     <= {5'b0, dg_len};
      end
    end
  end

endmodule

// File: tb/tb_ethercat_datagram_parser.sv
// Testbench for ethercat_datagram_parser. A frame-level model turns the byte
// list of each frame into expected headers, payload bytes, dg_end count and
// frame_err count; a negedge process checks every strobe against it.
// Honours DGRAM_CHAIN_EN for the chained-datagram expectations.
module tb_ethercat_datagram_parser;

  localparam int MAX_DG = 8;

  typedef logic [7:0] u8;
  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [15:0] len;
  } hdr_t;

  logic        rxc = 1'b0;
  logic        RSTN;
  logic        rx_dv;
  logic [3:0]  rx_data;
  logic [7:0]  sub_command;
  logic [31:0] sub_address;
  logic [15:0] sub_len;
  logic        subdv;
  logic [7:0]  dg_data;
  logic        dg_data_vld;
  logic        dg_end;
  logic        frame_err;

  always #5 rxc = ~rxc;

  ethercat_datagram_parser dut (
    .rxc         (rxc),
    .RSTN        (RSTN),
    .rx_dv       (rx_dv),
    .rx_data     (rx_data),
    .sub_command (sub_command),
    .sub_address (sub_address),
    .sub_len     (sub_len),
    .subdv       (subdv),
    .dg_data     (dg_data),
    .dg_data_vld (dg_data_vld),
    .dg_end      (dg_end),
    .frame_err   (frame_err)
  );

  int   vec  = 0;
  int   errs = 0;
  u8    frm[$];
  hdr_t exp_hdr[$];
  u8    exp_dat[$];
  int   exp_end, exp_err;
  int   act_end, act_err, act_hdr, act_dat;
  logic subdv_q = 1'b0;
  hdr_t h_cur;
  u8    d_cur;

  // Frame-level model: walks the post-SFD byte list using the protocol layout.
  task automatic model_frame(input u8 b[$]);
    int n, p, ndg, len;
`ifdef DGRAM_CHAIN_EN
    bit m;
`endif
    n = b.size();
    exp_hdr.delete(); exp_dat.delete();
    exp_end = 0; exp_err = 0;
    act_end = 0; act_err = 0; act_hdr = 0; act_dat = 0;
    if (n < 14) begin exp_err = 1; return; end
    if ({b[12], b[13]} != 16'h88A4) return;
    if (n < 16) begin exp_err = 1; return; end
    p = 16; ndg = 0;
    forever begin
      if (n < p + 10) begin exp_err = 1; return; end
      len = int'({b[p+7][2:0], b[p+6]});
`ifdef DGRAM_CHAIN_EN
      m = b[p+7][7];
`endif
      exp_hdr.push_back({b[p], b[p+5], b[p+4], b[p+3], b[p+2], 16'(len)});
      p += 10;
      for (int i = 0; i < len && p + i < n; i++) exp_dat.push_back(b[p+i]);
      if (n < p + len) begin exp_err = 1; return; end
      p += len;
      if (n < p + 2) begin exp_err = 1; return; end
      p += 2; exp_end++; ndg++;
`ifdef DGRAM_CHAIN_EN
      if (!m) return;
      if (ndg >= MAX_DG) begin exp_err = 1; return; end
`else
      return;
`endif
    end
  endtask

  always @(negedge rxc) begin
    if (RSTN) begin
      if (subdv) begin
        act_hdr++;
        vec++;
        if (exp_hdr.size() == 0) begin
          errs++;
          $display("FAIL subdv_unexpected: got cmd=%h addr=%h len=%h, required no header", sub_command, sub_address, sub_len);
        end else begin
          h_cur = exp_hdr.pop_front();
          if ({sub_command, sub_address, sub_len} != h_cur) begin
            errs++;
            $display("FAIL header: got cmd=%h addr=%h len=%h, required cmd=%h addr=%h len=%h",
                     sub_command, sub_address, sub_len, h_cur.cmd, h_cur.addr, h_cur.len);
          end
        end
        vec++;
        if (subdv_q) begin
          errs++;
          $display("FAIL subdv_width: got 2-cycle strobe, required 1 cycle");
        end
      end
      if (dg_data_vld) begin
        act_dat++;
        vec++;
        if (exp_dat.size() == 0) begin
          errs++;
          $display("FAIL data_unexpected: got %h, required no payload byte", dg_data);
        end else begin
          d_cur = exp_dat.pop_front();
          if (dg_data !== d_cur) begin
            errs++;
            $display("FAIL dg_data: got %h, required %h", dg_data, d_cur);
          end
        end
      end
      if (dg_end)    act_end++;
      if (frame_err) act_err++;
      subdv_q = subdv;
    end else begin
      subdv_q = 1'b0;
    end
  end

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] req);
    vec++;
    if (got !== req) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    rx_dv = 1'b1; rx_data = n;
    @(posedge rxc); #1;
  endtask

  task automatic send_byte(input u8 b);
    send_nib(b[3:0]);
    send_nib(b[7:4]);
  endtask

  task automatic end_frame();
    repeat (5) @(posedge rxc);
    @(negedge rxc); #1;
    check_val("hdr_missing", 64'(exp_hdr.size()), 64'd0);
    check_val("data_missing", 64'(exp_dat.size()), 64'd0);
    check_val("dg_end_count", 64'(act_end), 64'(exp_end));
    check_val("frame_err_count", 64'(act_err), 64'(exp_err));
    @(posedge rxc); #1;
  endtask

  task automatic send_frame(input bit keep_dv);
    model_frame(frm);
    repeat (7) send_byte(8'h55);
    send_byte(8'hD5);
    foreach (frm[i]) send_byte(frm[i]);
    if (!keep_dv) begin
      rx_dv = 1'b0; rx_data = 4'h0;
      end_frame();
    end
  endtask

  task automatic frame_prefix(input logic [15:0] etype);
    frm.delete();
    repeat (6) frm.push_back(8'hFF);
    frm.push_back(8'h02); repeat (4) frm.push_back(8'h00); frm.push_back(8'h01);
    frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
    frm.push_back(8'h0C); frm.push_back(8'h10);
  endtask

  task automatic add_hdr(input u8 cmd, input logic [31:0] addr, input logic [10:0] len, input logic m);
    frm.push_back(cmd); frm.push_back(8'h00);
    frm.push_back(addr[7:0]); frm.push_back(addr[15:8]);
    frm.push_back(addr[23:16]); frm.push_back(addr[31:24]);
    frm.push_back(len[7:0]); frm.push_back({m, 4'b0, len[10:8]});
    frm.push_back(8'h00); frm.push_back(8'h00);
  endtask

  task automatic frame1();
    frame_prefix(16'h88A4);
    add_hdr(8'h0A, 32'h14141414, 11'd2, 1'b0);
    frm.push_back(8'hAA); frm.push_back(8'hBB);
    frm.push_back(8'h00); frm.push_back(8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of run, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN = 1'b0; rx_dv = 1'b0; rx_data = 4'h0;
    #2;
    check_val("reset_outputs",
              64'({subdv, dg_data_vld, dg_end, frame_err, dg_data, sub_command, sub_len}), 64'd0);
    check_val("reset_addr", 64'(sub_address), 64'd0);
    repeat (2) @(posedge rxc); #1;
    RSTN = 1'b1;
    repeat (2) @(posedge rxc); #1;

    // 1: single datagram with two payload bytes
    frame1();
    send_frame(1'b0);
    check_val("t1_cmd", 64'(sub_command), 64'h0A);
    check_val("t1_addr", 64'(sub_address), 64'h14141414);
    check_val("t1_len", 64'(sub_len), 64'd2);
    check_val("t1_ndata", 64'(act_dat), 64'd2);
    check_val("t1_nhdr", 64'(act_hdr), 64'd1);

    // 2: foreign EtherType is dropped silently
    frame_prefix(16'h0800);
    add_hdr(8'h0A, 32'h14141414, 11'd2, 1'b0);
    frm.push_back(8'hAA); frm.push_back(8'hBB);
    frm.push_back(8'h00); frm.push_back(8'h00);
    send_frame(1'b0);
    check_val("t2_nhdr", 64'(act_hdr), 64'd0);
    check_val("t2_ndata", 64'(act_dat), 64'd0);
    check_val("t2_err", 64'(act_err), 64'd0);

    // 3: header truncated after 5 bytes
    frame_prefix(16'h88A4);
    add_hdr(8'h07, 32'hDEADBEEF, 11'd4, 1'b0);
    repeat (5) void'(frm.pop_back());
    send_frame(1'b0);
    check_val("t3_err", 64'(act_err), 64'd1);
    check_val("t3_cmd_kept", 64'(sub_command), 64'h0A);
    check_val("t3_addr_kept", 64'(sub_address), 64'h14141414);
    check_val("t3_len_kept", 64'(sub_len), 64'd2);

    // 4: zero-length datagram
    frame_prefix(16'h88A4);
    add_hdr(8'h04, 32'h00001000, 11'd0, 1'b0);
    frm.push_back(8'h00); frm.push_back(8'h00);
    send_frame(1'b0);
    check_val("t4_len", 64'(sub_len), 64'd0);
    check_val("t4_addr", 64'(sub_address), 64'h00001000);
    check_val("t4_ndata", 64'(act_dat), 64'd0);
    check_val("t4_end", 64'(act_end), 64'd1);

    // 5: two datagrams, first with M set
    frame_prefix(16'h88A4);
    add_hdr(8'h01, 32'h00000004, 11'd1, 1'b1);
    frm.push_back(8'h5A); frm.push_back(8'h00); frm.push_back(8'h00);
    add_hdr(8'h0C, 32'h14141413, 11'd2, 1'b0);
    frm.push_back(8'h11); frm.push_back(8'h22);
    frm.push_back(8'h00); frm.push_back(8'h00);
    send_frame(1'b0);
`ifdef DGRAM_CHAIN_EN
    check_val("t5_nhdr", 64'(act_hdr), 64'd2);
    check_val("t5_addr", 64'(sub_address), 64'h14141413);
    check_val("t5_ndata", 64'(act_dat), 64'd3);
`else
    check_val("t5_nhdr", 64'(act_hdr), 64'd1);
    check_val("t5_addr", 64'(sub_address), 64'h00000004);
    check_val("t5_ndata", 64'(act_dat), 64'd1);
`endif
    check_val("t5_err", 64'(act_err), 64'd0);

    // 6: reset in the middle of the payload aborts silently
    frame_prefix(16'h88A4);
    add_hdr(8'h0A, 32'h14141414, 11'd2, 1'b0);
    frm.push_back(8'hAA);
    send_frame(1'b1);
    exp_err = 0;
    send_nib(4'hB);
    RSTN = 1'b0;
    #1;
    check_val("t6_rst_outputs",
              64'({subdv, dg_data_vld, dg_end, frame_err, dg_data, sub_command, sub_len}), 64'd0);
    check_val("t6_rst_addr", 64'(sub_address), 64'd0);
    @(posedge rxc); #1;
    rx_dv = 1'b0; rx_data = 4'h0;
    RSTN = 1'b1;
    end_frame();
    check_val("t6_ndata", 64'(act_dat), 64'd1);
    frame1();
    send_frame(1'b0);
    check_val("t6_addr_after", 64'(sub_address), 64'h14141414);
    check_val("t6_ndata_after", 64'(act_dat), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
